// File: rtl/lsu_dmem_if.sv
// Core/memory bundle of the LSU data-memory port. Signal names keep the
// _i/_o suffixes as seen from lsu_dmem_port (slave side).
interface lsu_dmem_if #(
  parameter int XLEN = 32
);
  // Request handshake: a request transfers on a cycle where req_valid_i and
  // req_ready_o are both 1; mem_req_o holds its fields stable until mem_gnt_i.
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// Load/store unit data-memory port: checks one request, performs a single
// word-aligned memory access and returns an extended load result or an error.
module lsu_dmem_port #(
  parameter int XLEN      = 32,
  parameter int DMEM_SIZE = 1024
) (
  input  logic      clk_i,
  input  logic      rst_i,
  lsu_dmem_if.slave bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            req_err;
  logic [3:0]      be;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] load_val;
  logic            in_req;

  // Alignment, encoding and range check on the incoming request.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_we_i) begin
      case (bus.req_funct3_i)
        F3_B:    req_err = 1'b0;
        F3_H:    req_err = bus.req_addr_i[0];
        F3_W:    req_err = |bus.req_addr_i[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3_i)
        F3_B, F3_BU: req_err = 1'b0;
        F3_H, F3_HU: req_err = bus.req_addr_i[0];
        F3_W:        req_err = |bus.req_addr_i[1:0];
        default:     req_err = 1'b1;
      endcase
    end
    if (bus.req_addr_i >= XLEN'(DMEM_SIZE)) req_err = 1'b1;
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = 4'b0011 << addr_q[1:0];
      default: be = 4'b1111;
    endcase
  end

  // Unused lanes of sub-word stores are driven to zero.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   store_data = XLEN'(wdata_q[7:0])  << {addr_q[1:0], 3'b000};
      2'b01:   store_data = XLEN'(wdata_q[15:0]) << {addr_q[1:0], 3'b000};
      default: store_data = wdata_q;
    endcase
  end

  always_comb begin
    rd_shifted = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (f3_q)
      F3_B:    load_val = {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      F3_H:    load_val = {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      F3_BU:   load_val = {{(XLEN-8){1'b0}}, rd_shifted[7:0]};
      F3_HU:   load_val = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
      default: load_val = rd_shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          f3_d    = bus.req_funct3_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          if (req_err) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          if (we_q) begin
            state_d     = RESP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_val;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign in_req          = (state_q == REQ);
  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.mem_req_o   = in_req;
  assign bus.mem_we_o    = in_req & we_q;
  assign bus.mem_be_o    = in_req ? be : 4'b0000;
  assign bus.mem_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_wdata_o = (in_req && we_q) ? store_data : '0;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port: a transaction-level model predicts each
// response and memory access; a negedge process compares the DUT against it.
module tb_lsu_dmem_port;

  localparam int XLEN      = 32;
  localparam int DMEM_SIZE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [XLEN:0]   exp_q[$];
  logic            exp_mem_on = 1'b0;
  logic            exp_we;
  logic [3:0]      exp_be;
  logic [XLEN-1:0] exp_addr;
  logic [XLEN-1:0] exp_wdata;

  lsu_dmem_if #(.XLEN(XLEN)) bus ();

  lsu_dmem_port #(.XLEN(XLEN), .DMEM_SIZE(DMEM_SIZE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: derives outcome from access size, offset and legality rules.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata,
                                output logic err, output logic [31:0] rd,
                                output logic [3:0] be, output logic [31:0] mwd,
                                output logic [31:0] maddr);
    int unsigned      nbytes, off, be_i;
    longint unsigned  v, lim;
    bit               legal;
    off = addr % 4;
    case (f3[1:0])
      2'd0:    nbytes = 1;
      2'd1:    nbytes = 2;
      default: nbytes = 4;
    endcase
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((addr % nbytes) != 0) || (64'(addr) >= 64'(DMEM_SIZE));
    be_i  = ((1 << nbytes) - 1) << off;
    be    = be_i[3:0];
    maddr = addr - off;
    lim   = 64'd1 << (8 * nbytes);
    v     = (64'(wdata) % lim) << (8 * off);
    mwd   = we ? v[31:0] : 32'd0;
    v     = (64'(rdata) >> (8 * off)) % lim;
    if (!f3[2] && nbytes < 4 && v >= (lim / 2)) v = v + 64'h1_0000_0000 - lim;
    rd    = (err || we) ? 32'd0 : v[31:0];
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [XLEN:0] e;
    if (!rst) begin
      if (bus.rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata_o, e[XLEN-1:0]);
          check("rsp_err", bus.rsp_err_o, e[XLEN]);
        end
      end
      if (bus.mem_req_o) begin
        check("mem_req_allowed", exp_mem_on, 1'b1);
        check("mem_we", bus.mem_we_o, exp_we);
        check("mem_be", bus.mem_be_o, exp_be);
        check("mem_addr", bus.mem_addr_o, exp_addr);
        check("mem_wdata", bus.mem_wdata_o, exp_wdata);
      end else begin
        check("mem_idle_we", bus.mem_we_o, 1'b0);
        check("mem_idle_be", bus.mem_be_o, 4'b0000);
      end
    end
  end

  // driver: one request, memory responder, latency and hold checks
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_wait, input int exp_lat);
    logic        e_err;
    logic [31:0] e_rd, e_wd, e_ad;
    logic [3:0]  e_be;
    int          lat, gcnt, req_cyc;
    bit          done;
    model(we, f3, addr, wdata, rdata, e_err, e_rd, e_be, e_wd, e_ad);
    @(negedge clk);
    check({tag, "_ready_idle"}, bus.req_ready_o, 1'b1);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    exp_q.push_back({e_err, e_rd});
    exp_mem_on = !e_err;
    exp_we     = we;
    exp_be     = e_be;
    exp_addr   = e_ad;
    exp_wdata  = e_wd;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom_range(0, 32'hFFFF);
    bus.req_wdata_i = $urandom();
    lat = 1; gcnt = 0; req_cyc = 0; done = 0;
    while (!done && lat < 50) begin
      if (bus.rsp_valid_o) begin
        done = 1;
      end else begin
        check({tag, "_ready_busy"}, bus.req_ready_o, 1'b0);
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'hDEAD_BEEF;
        if (bus.mem_req_o) begin
          req_cyc++;
          if (gcnt >= gnt_wait) begin
            bus.mem_gnt_i = 1'b1;
          end else begin
            gcnt++;
            bus.mem_rvalid_i = 1'b1;
          end
        end else if (bus.busy_o) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rdata;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    check({tag, "_completed"}, done, 1'b1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ready_in_resp"}, bus.req_ready_o, 1'b0);
    check({tag, "_req_cycles"}, req_cyc, e_err ? 0 : gnt_wait + 1);
    @(negedge clk);
    exp_mem_on = 1'b0;
    check({tag, "_pulse_end"}, bus.rsp_valid_o, 1'b0);
    check({tag, "_ready_after"}, bus.req_ready_o, 1'b1);
    check({tag, "_rdata_held"}, bus.rsp_rdata_o, e_rd);
    check({tag, "_err_held"}, bus.rsp_err_o, e_err);
  endtask

  // driver: load abandoned by reset in REQ or WAIT, then a late rvalid
  task automatic run_reset(input string tag, input bit in_wait);
    logic        e_err;
    logic [31:0] e_rd, e_wd, e_ad;
    logic [3:0]  e_be;
    model(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, e_err, e_rd, e_be, e_wd, e_ad);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b010;
    bus.req_addr_i   = 32'h20;
    exp_mem_on = 1'b1;
    exp_we     = 1'b0;
    exp_be     = e_be;
    exp_addr   = e_ad;
    exp_wdata  = e_wd;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check({tag, "_in_req"}, bus.mem_req_o, 1'b1);
    if (in_wait) begin
      bus.mem_gnt_i = 1'b1;
      @(negedge clk);
      bus.mem_gnt_i = 1'b0;
      check({tag, "_in_wait"}, bus.mem_req_o, 1'b0);
    end
    check({tag, "_busy"}, bus.busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    exp_mem_on = 1'b0;
    check({tag, "_mem_req_dropped"}, bus.mem_req_o, 1'b0);
    check({tag, "_idle"}, bus.busy_o, 1'b0);
    check({tag, "_ready"}, bus.req_ready_o, 1'b1);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_late_rvalid_no_rsp"}, bus.rsp_valid_o, 1'b0);
      check({tag, "_late_rvalid_ready"}, bus.req_ready_o, 1'b1);
    end
    bus.mem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic        m_err;
    logic [31:0] m_rd, m_wd, m_ad;
    logic [3:0]  m_be;

    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    check("reset_ready", bus.req_ready_o, 1'b1);
    check("reset_busy", bus.busy_o, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    check("reset_rsp_err", bus.rsp_err_o, 1'b0);
    check("reset_mem_req", bus.mem_req_o, 1'b0);
    check("reset_mem_addr", bus.mem_addr_o, 32'h0);
    check("reset_mem_wdata", bus.mem_wdata_o, 32'h0);
    rst = 1'b0;

    // hand-computed pins on the model itself
    model(1'b1, 3'b000, 32'h6, 32'h1234_56AB, 32'h0, m_err, m_rd, m_be, m_wd, m_ad);
    check("model_sb_be", m_be, 4'b0100);
    check("model_sb_wdata", m_wd, 32'h00AB_0000);
    check("model_sb_addr", m_ad, 32'h4);
    model(1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF_FF7F, m_err, m_rd, m_be, m_wd, m_ad);
    check("model_lb", m_rd, 32'hFFFF_FF80);
    model(1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF_FF7F, m_err, m_rd, m_be, m_wd, m_ad);
    check("model_lh", m_rd, 32'hFFFF_80FF);
    model(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, m_err, m_rd, m_be, m_wd, m_ad);
    check("model_lw_range", m_err, 1'b1);

    run_req("sb6", 1'b1, 3'b000, 32'h6, 32'h1234_56AB, 32'h0, 0, 2);
    check("sb6_err", bus.rsp_err_o, 1'b0);
    run_req("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF_FF7F, 0, 3);
    check("lb3_value", bus.rsp_rdata_o, 32'hFFFF_FF80);
    run_req("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF_FF7F, 0, 3);
    check("lbu3_value", bus.rsp_rdata_o, 32'h0000_0080);
    run_req("lh2", 1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF_FF7F, 0, 3);
    check("lh2_value", bus.rsp_rdata_o, 32'hFFFF_80FF);
    run_req("lhu2", 1'b0, 3'b101, 32'h2, 32'h0, 32'h80FF_FF7F, 0, 3);
    check("lhu2_value", bus.rsp_rdata_o, 32'h0000_80FF);
    run_req("lh1_misal", 1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 0, 1);
    check("lh1_err", bus.rsp_err_o, 1'b1);
    run_req("sw5_misal", 1'b1, 3'b010, 32'h5, 32'hFFFF_FFFF, 32'h0, 0, 1);
    check("sw5_err", bus.rsp_err_o, 1'b1);
    check("sw5_rdata_zero", bus.rsp_rdata_o, 32'h0);
    run_req("lw400_range", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1);
    check("lw400_err", bus.rsp_err_o, 1'b1);
    run_req("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFE_F00D, 0, 3);
    check("lw3fc_value", bus.rsp_rdata_o, 32'hCAFE_F00D);
    check("lw3fc_err", bus.rsp_err_o, 1'b0);
    run_req("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1);
    run_req("st_f3_100", 1'b1, 3'b100, 32'h0, 32'h55, 32'h0, 0, 1);
    run_req("sh2_slow", 1'b1, 3'b001, 32'h2, 32'h0000_BEEF, 32'h0, 5, 7);
    run_req("lw8_slow", 1'b0, 3'b010, 32'h8, 32'h0, 32'h1357_9BDF, 3, 6);
    check("lw8_value", bus.rsp_rdata_o, 32'h1357_9BDF);
    run_req("sw10", 1'b1, 3'b010, 32'h10, 32'hA5A5_0F0F, 32'h0, 0, 2);
    run_reset("rst_req", 1'b0);
    run_reset("rst_wait", 1'b1);
    run_req("lbu_after_rst", 1'b0, 3'b100, 32'h21, 32'h0, 32'h0000_C300, 1, 4);
    check("lbu_after_rst_value", bus.rsp_rdata_o, 32'h0000_00C3);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
